// File: rtl/main_mem_ctrl.sv
// Initiator-side controller for the 128-bit main-memory bus: accepts one line
// request at a time, sequences CS/OE/WE/Addr/Data and reports completion or timeout.
module main_mem_ctrl #(
    parameter int Data_Width = 128,
    parameter int Addr_Width = 25,
    parameter int Timeout    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [Addr_Width-1:0] req_addr,
    input  logic [Data_Width-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_we,
    output logic                  resp_err,
    output logic [Data_Width-1:0] resp_rdata,
    output logic                  CS,
    output logic                  OE,
    output logic                  WE,
    output logic [Addr_Width-1:0] Addr,
    inout  wire  [Data_Width-1:0] Data,
    input  logic                  Ready_Mem
);

    localparam int CntW = (Timeout > 1) ? $clog2(Timeout) + 1 : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  run;
    logic                  accept;
    logic                  we_q;
    logic                  we_sel;
    logic                  err_q;
    logic                  timeout_hit;
    logic                  bus_on;
    logic [CntW-1:0]       wd_cnt;
    logic [Data_Width-1:0] wdata_q;
    logic [Data_Width-1:0] rd_cap;

    // run keeps req_ready low while reset is held and for the first edge after it
    assign req_ready  = run && (state == IDLE) && Ready_Mem;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == DONE);
    assign resp_we    = resp_valid && we_q;
    assign resp_err   = resp_valid && err_q;

    // WE and the data driver share one flop, so Data can never be driven with WE low
    assign Data = WE ? wdata_q : {Data_Width{1'bz}};

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: begin
                if (!Ready_Mem) begin
                    state_nxt = BUSY;
                end else if ((Timeout != 0) && (wd_cnt == CntW'(Timeout - 1))) begin
                    state_nxt   = DONE;
                    timeout_hit = 1'b1;
                end
            end
            BUSY:  if (Ready_Mem) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_on = (state_nxt == ISSUE) || (state_nxt == BUSY);
    assign we_sel = accept ? req_we : we_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            run        <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            wd_cnt     <= '0;
            CS         <= 1'b0;
            OE         <= 1'b0;
            WE         <= 1'b0;
            Addr       <= '0;
            resp_rdata <= '0;
        end else begin
            state  <= state_nxt;
            run    <= 1'b1;
            err_q  <= timeout_hit;
            wd_cnt <= (state == ISSUE) ? wd_cnt + CntW'(1) : '0;
            if (accept) begin
                we_q <= req_we;
                Addr <= req_addr;
            end
            CS <= bus_on;
            OE <= bus_on && !we_sel;
            WE <= bus_on && we_sel;
            // a read completes on the edge leaving BUSY; rd_cap holds the last busy-cycle sample
            if ((state == BUSY) && Ready_Mem && !we_q)
                resp_rdata <= rd_cap;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            wdata_q <= req_wdata;
        if ((state == BUSY) && !Ready_Mem && !we_q)
            rd_cap <= Data;
    end

endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
- Initiator-side controller for the 128-bit, 25-bit-address main-memory bus (CS/OE/WE/Addr/Data/Ready_Mem).
- Accepts single-line read and write requests from the cache side over a valid/ready handshake.
- Sequences the bus, waits out the multi-cycle busy window and returns read data or a write acknowledge.
- Includes a watchdog that flags a memory that never responds.

Parameters:
- Data_Width, 128, line/bus data width.
- Addr_Width, 25, line address width.
- Timeout, 16, max cycles to wait for Ready_Mem to fall after issue; 0 disables the watchdog.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  cache request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_we  input  1  1 = write line, 0 = read line.
- req_addr  input  Addr_Width  line address.
- req_wdata  input  Data_Width  write line data.
- resp_valid  output  1  one-cycle pulse: transaction complete.
- resp_we  output  1  echo of the completed request's req_we.
- resp_err  output  1  completion was a watchdog timeout.
- resp_rdata  output  Data_Width  read line; holds last value until the next read completes.
- CS  output  1  memory chip select.
- OE  output  1  memory output enable (reads).
- WE  output  1  memory write enable.
- Addr  output  Addr_Width  memory address.
- Data  inout  Data_Width  memory data bus; driven only during writes, else high-Z.
- Ready_Mem  input  1  memory idle (1) / busy (0).

Behaviour:
- Reset values:
  - Outputs: req_ready=0, resp_valid=0, resp_we=0, resp_err=0, resp_rdata=0, CS=0, OE=0, WE=0, Addr=0.
  - Data released (high-Z); state=IDLE; watchdog counter=0.
- Reset mid-transaction aborts immediately: bus deasserted, no response produced.
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - req_ready=1 iff Ready_Mem=1.
  - On req_valid&&req_ready, latch we/addr/wdata and go to ISSUE.
  - req_ready drops the following cycle.
- ISSUE:
  - Registered CS=1 and Addr=latched addr.
  - Write: WE=1, OE=0, Data driven with latched wdata.
  - Read: WE=0, OE=1, Data high-Z.
  - Watchdog counts cycles in ISSUE.
  - On Ready_Mem=0, go to BUSY.
  - If Timeout≠0 and count reaches Timeout, go to DONE with err=1.
- BUSY:
  - CS/WE/OE/Addr held; write data remains driven.
  - On each cycle of a read with Ready_Mem=0, capture Data into an internal read register.
  - On Ready_Mem=1, go to DONE.
  - No watchdog in BUSY.
- DONE (one cycle):
  - CS=OE=WE=0, Data released.
  - resp_valid=1, resp_we=latched we, resp_err=err.
  - On a successful read, resp_rdata is loaded from the last captured value in the same cycle.
  - Go to IDLE; err cleared.
- Latency: request accept to resp_valid = 1 (ISSUE entry) + cycles until Ready_Mem falls + busy length + 1.
  - Against a memory with a 2-cycle busy window, minimum is 5 cycles.
- Bus rules:
  - CS is never asserted with both WE and OE high.
  - Data is never driven while WE=0.
  - Addr is stable for the whole CS-high window.
- Back-to-back: a new request is accepted no earlier than the cycle after DONE, and only if Ready_Mem=1.
- Ready_Mem glitch low while IDLE is ignored.
- A timeout does not recover the memory. The next request still waits for Ready_Mem=1 in IDLE.
- Read data on Data is sampled only in BUSY; Z/X outside that window must not reach resp_rdata.

Test Plan:
- Write then read: write addr 0x0000010 data 0xDEADBEEF_00000000_CAFEF00D_12345678, then read the same addr.
  - Write: resp_valid with resp_we=1, resp_err=0.
  - Read: resp_rdata equals that value; WE/OE mutually exclusive throughout.
- Back-to-back: hold req_valid high for 3 reads to addrs 0,1,2 preloaded 0xA/0xB/0xC.
  - Exactly 3 resp_valid pulses, in order, with rdata 0xA, 0xB, 0xC.
  - req_ready low between accepts.
- Busy stretch: the memory model holds Ready_Mem=0 for 6 cycles on a read.
  - CS/Addr stable for the whole window; resp_valid exactly 1 cycle after Ready_Mem rises.
- Watchdog: Timeout=4 and Ready_Mem tied 1, then issue a read.
  - resp_valid with resp_err=1 exactly 5 cycles after accept; resp_rdata unchanged.
  - With Timeout=0, no response ever occurs.
- Reset mid-read: assert reset during BUSY.
  - CS/OE/WE=0 and Data high-Z asynchronously; no resp_valid.
  - After release, a new read completes normally.
- Ready_Mem low in IDLE: req_ready=0 while Ready_Mem=0. A pending req_valid is accepted the cycle Ready_Mem returns to 1.
